// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin time-sharing of one 19x19 multiplier with grant lock
module mult_share_arbiter #(
    parameter int N   = 4,
    parameter int LAT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    lock,
    input  logic [19*N-1:0] a_in,
    input  logic [19*N-1:0] b_in,
    output logic [N-1:0]    gnt,
    output logic [18:0]     mula,
    output logic [18:0]     mulb,
    input  logic [36:0]     mulc,
    output logic [36:0]     c_out,
    output logic [N-1:0]    c_valid,
    output logic            busy
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] owner;
    logic [IW-1:0] last_idx;
    logic [IW-1:0] base;
    logic [N-1:0]  gnt_nxt;
    logic [18:0]   a_sel;
    logic [18:0]   b_sel;
    logic          xfer;
    logic          hold;
    logic          found;
    logic [LAT:0]  tag_v;
    logic [IW-1:0] tag_idx [0:LAT];

    always_comb begin
        owner = '0;
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                owner = IW'(i);
                a_sel = a_in[19*i +: 19];
                b_sel = b_in[19*i +: 19];
            end
        end
    end

    assign xfer = |(req & gnt);
    assign hold = |(gnt & lock);
    // The transferring requester becomes lowest priority at the very edge it transfers.
    assign base = xfer ? owner : last_idx;

    always_comb begin
        gnt_nxt = '0;
        found   = 1'b0;
        if (hold) begin
            gnt_nxt = gnt;
        end else begin
            for (int k = 0; k < N; k++) begin
                for (int i = 0; i < N; i++) begin
                    if (!found && req[i] && ((int'(base) + 1 + k) % N) == i) begin
                        gnt_nxt[i] = 1'b1;
                        found      = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt      <= '0;
            last_idx <= IW'(N - 1);
            mula     <= '0;
            mulb     <= '0;
            c_out    <= '0;
            c_valid  <= '0;
            tag_v    <= '0;
            for (int s = 0; s <= LAT; s++) begin
                tag_idx[s] <= '0;
            end
        end else begin
            gnt <= gnt_nxt;
            // A locked owner counts as last owner so release arbitrates past it.
            if (xfer || hold) begin
                last_idx <= owner;
            end
            if (xfer) begin
                mula <= a_sel;
                mulb <= b_sel;
            end
            tag_v[0]   <= xfer;
            tag_idx[0] <= owner;
            for (int s = 1; s <= LAT; s++) begin
                tag_v[s]   <= tag_v[s-1];
                tag_idx[s] <= tag_idx[s-1];
            end
            c_valid <= '0;
            for (int i = 0; i < N; i++) begin
                if (tag_v[LAT] && tag_idx[LAT] == IW'(i)) begin
                    c_valid[i] <= 1'b1;
                end
            end
            if (tag_v[LAT]) begin
                c_out <= mulc;
            end
        end
    end

    assign busy = |tag_v;

endmodule
